pwm_servo_decoder: RTL and testbench

- 4-channel servo-PWM pulse-width decoder on the 50 MHz clock (0.02 µs/cycle).
- Measures the high time of each incoming servo pulse and converts it back to an 8-bit angle using the team's servo mapping: 544 µs = 0°, 515 cycles/degree, 180° max.
- Used for loopback checking of the servo PWM generator and for reading external RC/servo command signals.

---
 rtl/pwm_servo_decoder_if.sv | 21 ++
 rtl/pwm_servo_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_pwm_servo_decoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_servo_decoder_if.sv
// Signal bundle between a servo PWM source and the pulse-width decoder.
interface pwm_servo_decoder_if;
   logic [3:0] servo_in;
   logic [7:0] angle1;
   logic [7:0] angle2;
   logic [7:0] angle3;
   logic [7:0] angle4;
   logic [3:0] valid;
   logic [3:0] new_angle;
   logic [3:0] err;

   modport master (
      output servo_in,
      input  angle1, angle2, angle3, angle4, valid, new_angle, err
   );

   modport slave (
      input  servo_in,
      output angle1, angle2, angle3, angle4, valid, new_angle, err
   );
endinterface

// File: rtl/pwm_servo_decoder.sv
// 4-channel servo PWM high-time decoder with a shared angle converter.
//
// Channel FSM
//   state    | meaning
//   WAIT_LOW | waiting to see the line low before trusting edges
//   LOW      | line low, waiting for a rising edge
//   HIGH     | counting high time of the current pulse
//
// Converter FSM
//   state    | meaning
//   CV_IDLE  | round-robin pick of a pending channel, load remainder
//   CV_SUB   | repeated subtraction of CYC_PER_DEG, one degree per cycle
//   CV_DONE  | publish angle, set valid, clear err and pend
module pwm_servo_decoder #(
   parameter int MIN_CYCLES       = 27200,
   parameter int CYC_PER_DEG      = 515,
   parameter int MAX_ANGLE        = 180,
   parameter int MAX_PULSE_CYCLES = 130000,
   parameter int TIMEOUT_CYCLES   = 2000000
) (
   input  logic           clk,
   input  logic           rst,
   pwm_servo_decoder_if.slave bus
);

   localparam logic [17:0] MIN_C  = 18'(MIN_CYCLES);
   localparam logic [17:0] CPD_C  = 18'(CYC_PER_DEG);
   localparam logic [7:0]  MAXA_C = 8'(MAX_ANGLE);
   localparam logic [17:0] MAXP_M1 = 18'(MAX_PULSE_CYCLES - 1);
   localparam logic [20:0] TO_LIM = 21'(TIMEOUT_CYCLES);
   localparam logic [20:0] TO_M1  = 21'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {WAIT_LOW, LOW, HIGH} ch_state_t;
   typedef enum logic [1:0] {CV_IDLE, CV_SUB, CV_DONE} cv_state_t;

   logic [3:0]  s0, s1, s_prev;
   logic [1:0]  fill;
   logic        sync_ok;
   logic [3:0]  rise, fall;

   ch_state_t   ch_state [4];
   logic [17:0] cnt [4];
   logic [20:0] to_cnt [4];
   logic [17:0] pend_width [4];
   logic [3:0]  pend;
   logic [3:0]  valid_r;
   logic [3:0]  err_r;

   cv_state_t   cv_state;
   logic [1:0]  sel;
   logic [1:0]  last;
   logic [17:0] rem;
   logic [7:0]  q;
   logic [7:0]  angle_r [4];
   logic [3:0]  new_angle_r;

   logic [3:0]  done_hit;
   logic [1:0]  pick;
   logic        pick_ok;
   logic [1:0]  idx;

   assign sync_ok = (fill == 2'd2);
   assign rise    = s1 & ~s_prev;
   assign fall    = ~s1 & s_prev;

   // Two-flop synchroniser, edge-detect history, and a fill counter so the
   // reset value of the synchroniser is never mistaken for a real low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0     <= '0;
         s1     <= '0;
         s_prev <= '0;
         fill   <= '0;
      end else begin
         s0     <= bus.servo_in;
         s1     <= s0;
         s_prev <= s1;
         if (fill != 2'd2) fill <= fill + 2'd1;
      end
   end

   // Channel currently being published by the converter.
   always_comb begin
      done_hit = '0;
      if (cv_state == CV_DONE) done_hit[sel] = 1'b1;
   end

   // Round-robin pick starting with the channel after the last one served.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      idx     = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!pick_ok && pend[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   // Per-channel pulse measurement, timeout and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            ch_state[i]   <= WAIT_LOW;
            cnt[i]        <= '0;
            to_cnt[i]     <= '0;
            pend_width[i] <= '0;
         end
         pend    <= '0;
         valid_r <= '0;
         err_r   <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            // Converter release first so a same-cycle capture keeps pend set.
            if (done_hit[i]) begin
               pend[i]    <= 1'b0;
               valid_r[i] <= 1'b1;
               err_r[i]   <= 1'b0;
            end

            if (rise[i])
               to_cnt[i] <= '0;
            else if (to_cnt[i] != TO_LIM)
               to_cnt[i] <= to_cnt[i] + 21'd1;

            if (!rise[i] && to_cnt[i] >= TO_M1)
               valid_r[i] <= 1'b0;

            case (ch_state[i])
               WAIT_LOW: begin
                  if (sync_ok && !s1[i]) ch_state[i] <= LOW;
               end
               LOW: begin
                  if (rise[i]) begin
                     cnt[i]      <= 18'd1;
                     ch_state[i] <= HIGH;
                  end
               end
               HIGH: begin
                  if (fall[i]) begin
                     pend_width[i] <= cnt[i];
                     pend[i]       <= 1'b1;
                     ch_state[i]   <= LOW;
                  end else if (cnt[i] >= MAXP_M1) begin
                     err_r[i]    <= 1'b1;
                     ch_state[i] <= WAIT_LOW;
                  end else begin
                     cnt[i] <= cnt[i] + 18'd1;
                  end
               end
               default: ch_state[i] <= WAIT_LOW;
            endcase
         end
      end
   end

   // Shared width-to-angle converter: floor division by repeated subtraction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cv_state    <= CV_IDLE;
         sel         <= '0;
         last        <= 2'd3;
         rem         <= '0;
         q           <= '0;
         new_angle_r <= '0;
         for (int i = 0; i < 4; i++) angle_r[i] <= '0;
      end else begin
         new_angle_r <= '0;
         case (cv_state)
            CV_IDLE: begin
               if (pick_ok) begin
                  sel      <= pick;
                  rem      <= (pend_width[pick] < MIN_C) ? '0 : pend_width[pick] - MIN_C;
                  q        <= '0;
                  cv_state <= CV_SUB;
               end
            end
            CV_SUB: begin
               if (rem >= CPD_C && q < MAXA_C) begin
                  rem <= rem - CPD_C;
                  q   <= q + 8'd1;
               end else begin
                  cv_state <= CV_DONE;
               end
            end
            CV_DONE: begin
               angle_r[sel]     <= q;
               new_angle_r[sel] <= 1'b1;
               last             <= sel;
               cv_state         <= CV_IDLE;
            end
            default: cv_state <= CV_IDLE;
         endcase
      end
   end

   assign bus.angle1    = angle_r[0];
   assign bus.angle2    = angle_r[1];
   assign bus.angle3    = angle_r[2];
   assign bus.angle4    = angle_r[3];
   assign bus.valid     = valid_r;
   assign bus.new_angle = new_angle_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_pwm_servo_decoder.sv
// Directed bench for pwm_servo_decoder with scaled-down timing parameters.
module tb_pwm_servo_decoder;

   localparam int MIN  = 200;
   localparam int CPD  = 10;
   localparam int MAXA = 180;
   localparam int MAXP = 2200;
   localparam int TO   = 4000;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   pwm_servo_decoder_if bus ();

   pwm_servo_decoder #(
      .MIN_CYCLES      (MIN),
      .CYC_PER_DEG     (CPD),
      .MAX_ANGLE       (MAXA),
      .MAX_PULSE_CYCLES(MAXP),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int ch;
      int ang;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int t_rise      = 0;

   function automatic int angle_of(int i);
      case (i)
         0: return int'(bus.angle1);
         1: return int'(bus.angle2);
         2: return int'(bus.angle3);
         default: return int'(bus.angle4);
      endcase
   endfunction

   function automatic int model(int w);
      int a;
      if (w < MIN) return 0;
      a = (w - MIN) / CPD;
      return (a > MAXA) ? MAXA : a;
   endfunction

   // Log every strobe with the angle presented alongside it.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++)
         if (bus.new_angle[i] === 1'b1) obs_q.push_back('{i, angle_of(i)});
   end

   task automatic check(input string tag, input int obs, input int exp_v);
      vectors++;
      assert (obs === exp_v)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic pulse(input int ch, input int w, input bit push);
      @(posedge clk);
      #1;
      bus.servo_in[ch] = 1'b1;
      t_rise = cyc;
      repeat (w) @(posedge clk);
      #1;
      bus.servo_in[ch] = 1'b0;
      if (push) exp_q.push_back('{ch, model(w)});
   endtask

   task automatic drain(input int budget);
      ev_t o, e;
      int  n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check("strobe_ch", o.ch, e.ch);
            check("strobe_angle", o.ang, e.ang);
         end else begin
            @(posedge clk);
            #2;
            n++;
         end
      end
      if (exp_q.size() > 0) begin
         check("strobe_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (10) @(posedge clk);
      #2;
      check("extra_strobe", obs_q.size(), 0);
      obs_q.delete();
   endtask

   initial begin
      int w [4];
      int len;

      bus.servo_in = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_angle1", angle_of(0), 0);
      check("rst_angle4", angle_of(3), 0);
      check("rst_valid", int'(bus.valid), 0);
      check("rst_new_angle", int'(bus.new_angle), 0);
      check("rst_err", int'(bus.err), 0);
      rst = 1'b0;
      repeat (20) @(posedge clk);

      // Minimum width
      pulse(0, 200, 1'b1);
      drain(400);
      check("ch1_valid", int'(bus.valid[0]), 1);

      // Midpoint and floor
      pulse(1, 1100, 1'b1);
      drain(400);
      pulse(1, 1099, 1'b1);
      drain(400);
      check("ch2_angle_hold", angle_of(1), 89);

      // Upper and lower clamps
      pulse(2, 2000, 1'b1);
      drain(400);
      check("ch3_err_a", int'(bus.err[2]), 0);
      pulse(2, 2100, 1'b1);
      drain(400);
      check("ch3_err_b", int'(bus.err[2]), 0);
      pulse(2, 150, 1'b1);
      drain(400);
      check("ch3_err_c", int'(bus.err[2]), 0);
      check("ch3_valid_short", int'(bus.valid[2]), 1);

      // Over-length fault
      pulse(3, 650, 1'b1);
      drain(400);
      @(posedge clk);
      #1;
      bus.servo_in[3] = 1'b1;
      repeat (MAXP + 1) @(posedge clk);
      #1;
      check("ch4_err_before_limit", int'(bus.err[3]), 0);
      @(posedge clk);
      #1;
      check("ch4_err_at_limit", int'(bus.err[3]), 1);
      repeat (2500 - MAXP - 2) @(posedge clk);
      #1;
      bus.servo_in[3] = 1'b0;
      repeat (300) @(posedge clk);
      #2;
      check("ch4_fault_no_strobe", obs_q.size(), 0);
      check("ch4_angle_unchanged", angle_of(3), 45);
      check("ch4_err_sticky", int'(bus.err[3]), 1);
      obs_q.delete();
      repeat (20) @(posedge clk);
      pulse(3, 200, 1'b1);
      drain(400);
      check("ch4_err_cleared", int'(bus.err[3]), 0);
      pulse(3, MAXP - 1, 1'b1);
      drain(400);
      check("ch4_err_just_under", int'(bus.err[3]), 0);

      // Simultaneous falls on all four channels
      w[0] = 200; w[1] = 650; w[2] = 1100; w[3] = 2000;
      len = 2000;
      repeat (20) @(posedge clk);
      for (int c = 0; c < len; c++) begin
         #1;
         for (int i = 0; i < 4; i++)
            if (c == len - w[i]) bus.servo_in[i] = 1'b1;
         @(posedge clk);
      end
      #1;
      bus.servo_in = '0;
      for (int i = 0; i < 4; i++) exp_q.push_back('{i, model(w[i])});
      drain(1500);
      check("all_valid", int'(bus.valid), 15);

      // Timeout measured from the last rising edge
      repeat (20) @(posedge clk);
      pulse(0, 300, 1'b1);
      drain(400);
      repeat (t_rise + TO + 2 - cyc) @(posedge clk);
      #2;
      check("timeout_valid_before", int'(bus.valid[0]), 1);
      @(posedge clk);
      #2;
      check("timeout_valid_after", int'(bus.valid[0]), 0);
      check("timeout_angle_hold", angle_of(0), 10);

      // Reset during a conversion
      repeat (20) @(posedge clk);
      pulse(2, 2000, 1'b0);
      repeat (60) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_angle1", angle_of(0), 0);
      check("midrst_angle2", angle_of(1), 0);
      check("midrst_angle4", angle_of(3), 0);
      check("midrst_valid", int'(bus.valid), 0);
      check("midrst_err", int'(bus.err), 0);
      check("midrst_new_angle", int'(bus.new_angle), 0);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (400) @(posedge clk);
      #2;
      check("midrst_no_strobe", obs_q.size(), 0);
      obs_q.delete();

      // Line high at reset release is not measured
      rst = 1'b1;
      bus.servo_in[1] = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      bus.servo_in[1] = 1'b0;
      repeat (300) @(posedge clk);
      #2;
      check("startup_high_no_strobe", obs_q.size(), 0);
      check("startup_high_valid", int'(bus.valid[1]), 0);
      obs_q.delete();
      pulse(1, 1100, 1'b1);
      drain(400);
      check("startup_recover_valid", int'(bus.valid[1]), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
